// File: rtl/cond_flag_unit_if.sv
// Decoder/ALU <-> condition unit bundle: requests and ALU status in, gated commits and flags out.
interface cond_flag_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       Stall;
  logic       ErrClr;
  logic [3:0] Flags;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondErr;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall, ErrClr,
    input  Flags, CondEx, PCSrc, RegWrite, MemWrite, CondErr
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall, ErrClr,
    output Flags, CondEx, PCSrc, RegWrite, MemWrite, CondErr
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register plus condition check; gates decoder commits on the stored flags.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic           clk,
  input  logic           reset,
  cond_flag_unit_if.slave bus
);
  logic [3:0] flags_q, flags_d;
  logic       cond_err_q, cond_err_d;
  logic       cond_ex;
  logic       commit_ok;
  logic [1:0] flag_write;
  logic       n, z, c, v;
  logic       any_req;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign commit_ok  = cond_ex & ~bus.Stall;
  assign flag_write = bus.FlagW & {2{commit_ok}};
  assign any_req    = bus.PCS | bus.RegW | bus.MemW | (|bus.FlagW);

  // No bypass: CondEx always reads the registered flags, never ALUFlags.
  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = bus.ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  // Set beats clear so a new reserved-condition hit is never lost.
  always_comb begin
    cond_err_d = cond_err_q;
    if (bus.ErrClr) cond_err_d = 1'b0;
    if ((bus.Cond == 4'b1111) && any_req && !bus.Stall) cond_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= FLAG_RESET;
      cond_err_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      cond_err_q <= cond_err_d;
    end
  end

  assign bus.Flags    = flags_q;
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  & commit_ok;
  assign bus.RegWrite = bus.RegW & commit_ok & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & commit_ok;
  assign bus.CondErr  = cond_err_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed vector table plus randomized run against a condition/flag reference model.
module tb_cond_flag_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cond_flag_unit_if bus ();

  cond_flag_unit #(.FLAG_RESET(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pcs, regw, memw, nowrite, stall, errclr;
    logic       e_condex, e_pcsrc, e_regwrite, e_memwrite;
    logic [3:0] e_flags;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                              input logic [1:0] flagw, input logic pcs, input logic regw,
                              input logic memw, input logic nowrite, input logic stall,
                              input logic errclr, input logic ce, input logic ps,
                              input logic rw, input logic mw, input logic [3:0] fl,
                              input logic er);
    vec_t t;
    t.rst = rst; t.cond = cond; t.alu = alu; t.flagw = flagw; t.pcs = pcs; t.regw = regw;
    t.memw = memw; t.nowrite = nowrite; t.stall = stall; t.errclr = errclr;
    t.e_condex = ce; t.e_pcsrc = ps; t.e_regwrite = rw; t.e_memwrite = mw;
    t.e_flags = fl; t.e_err = er;
    return t;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] cond, input logic [3:0] alu,
                       input logic [1:0] flagw, input logic pcs, input logic regw,
                       input logic memw, input logic nowrite, input logic stall,
                       input logic errclr);
    reset = rst; bus.Cond = cond; bus.ALUFlags = alu; bus.FlagW = flagw;
    bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw; bus.NoWrite = nowrite;
    bus.Stall = stall; bus.ErrClr = errclr;
  endtask

  // Reference condition: base test chosen by Cond[3:1], Cond[0] inverts it.
  function automatic logic model_pass(input logic [3:0] cond, input logic [3:0] f);
    logic nn, zz, cc, vv, r;
    nn = f[3]; zz = f[2]; cc = f[1]; vv = f[0];
    case (cond[3:1])
      3'd0: r = zz;
      3'd1: r = cc;
      3'd2: r = nn;
      3'd3: r = vv;
      3'd4: r = cc && !zz;
      3'd5: r = (nn == vv);
      3'd6: r = !zz && (nn == vv);
      default: r = 1'b1;
    endcase
    return cond[0] ? !r : r;
  endfunction

  initial begin
    logic [3:0] m_flags;
    logic       m_err;
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 4'b1110, 4'b0, 2'b0, 0, 0, 0, 0, 0, 0);

    // Vector table, applied in order; expected flags/err are after the edge.
    //          rst cond     alu      fw     pcs regw memw nw st ec  ce ps rw mw flags    err
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0,  1, 0, 0, 1, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0001, 4'b0000, 2'b11, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1100, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0010, 2'b01, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1110, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b1000, 2'b11, 0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1100, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1010, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1101, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1110, 4'b0110, 2'b11, 1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1001, 1));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1001, 1));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 1,  0, 0, 0, 0, 4'b1001, 1));
    vecs.push_back(mk(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 4'b1001, 0));
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 2'b01, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1001, 1));
    vecs.push_back(mk(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 0));

    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 4'b1110, 4'b0, 2'b0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_flags", bus.Flags, 4'b0000);
    chk("reset_err", {3'b0, bus.CondErr}, 4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].cond, vecs[i].alu, vecs[i].flagw, vecs[i].pcs, vecs[i].regw,
            vecs[i].memw, vecs[i].nowrite, vecs[i].stall, vecs[i].errclr);
      #1;
      chk($sformatf("v%0d_condex", i), {3'b0, bus.CondEx}, {3'b0, vecs[i].e_condex});
      chk($sformatf("v%0d_pcsrc", i), {3'b0, bus.PCSrc}, {3'b0, vecs[i].e_pcsrc});
      chk($sformatf("v%0d_regwrite", i), {3'b0, bus.RegWrite}, {3'b0, vecs[i].e_regwrite});
      chk($sformatf("v%0d_memwrite", i), {3'b0, bus.MemWrite}, {3'b0, vecs[i].e_memwrite});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flags", i), bus.Flags, vecs[i].e_flags);
      chk($sformatf("v%0d_err", i), {3'b0, bus.CondErr}, {3'b0, vecs[i].e_err});
    end

    // Randomized run; the table left the unit in reset state.
    m_flags = 4'b0000;
    m_err   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      logic       r_rst, pass, go;
      logic [3:0] r_cond, r_alu, mask;
      logic [1:0] r_fw;
      logic       r_pcs, r_regw, r_memw, r_nw, r_st, r_ec;
      @(negedge clk);
      r_rst  = ($urandom_range(0, 31) == 0);
      r_cond = 4'($urandom_range(0, 15));
      r_alu  = 4'($urandom_range(0, 15));
      r_fw   = 2'($urandom_range(0, 3));
      r_pcs  = 1'($urandom_range(0, 1));
      r_regw = 1'($urandom_range(0, 1));
      r_memw = 1'($urandom_range(0, 1));
      r_nw   = 1'($urandom_range(0, 1));
      r_st   = ($urandom_range(0, 3) == 0);
      r_ec   = ($urandom_range(0, 7) == 0);
      drive(r_rst, r_cond, r_alu, r_fw, r_pcs, r_regw, r_memw, r_nw, r_st, r_ec);
      pass = model_pass(r_cond, m_flags);
      go   = pass && !r_st;
      #1;
      chk("rnd_condex", {3'b0, bus.CondEx}, {3'b0, pass});
      chk("rnd_pcsrc", {3'b0, bus.PCSrc}, {3'b0, r_pcs && go});
      chk("rnd_regwrite", {3'b0, bus.RegWrite}, {3'b0, r_regw && go && !r_nw});
      chk("rnd_memwrite", {3'b0, bus.MemWrite}, {3'b0, r_memw && go});
      @(posedge clk);
      if (r_rst) begin
        m_flags = 4'b0000;
        m_err   = 1'b0;
      end else begin
        mask    = go ? {r_fw[1], r_fw[1], r_fw[0], r_fw[0]} : 4'b0000;
        m_flags = (m_flags & ~mask) | (r_alu & mask);
        if (r_cond == 4'b1111 && !r_st && (r_pcs || r_regw || r_memw || r_fw != 2'b00))
          m_err = 1'b1;
        else if (r_ec)
          m_err = 1'b0;
      end
      #1;
      chk("rnd_flags", bus.Flags, m_flags);
      chk("rnd_err", {3'b0, bus.CondErr}, {3'b0, m_err});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
